// File: rtl/wb_commit.sv
// Writeback commit unit: drives the GPR write port and trace signals, and owns
// the architectural HI/LO pair, the LL/SC link bit and the retirement counter.
module wb_commit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [4:0]  wb_wd,
    input  logic        wb_wreg,
    input  logic [31:0] wb_wdata,
    input  logic        wb_whilo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    input  logic        wb_LLbit_we,
    input  logic        wb_LLbit_value,
    input  logic        flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        LLbit_o,
    output logic        LLbit_fwd,
    output logic [31:0] instret,
    output logic [31:0] last_pc,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic hilo_we;
    logic llbit_we;

    assign hilo_we  = wb_valid & wb_whilo;
    assign llbit_we = wb_valid & wb_LLbit_we;

    // Zero-latency GPR write port and trace outputs
    always_comb begin
        rf_we             = wb_valid & wb_wreg;
        rf_waddr          = wb_wd;
        rf_wdata          = wb_wdata;
        debug_wb_pc       = wb_valid ? wb_pc : RESET_PC;
        debug_wb_rf_wen   = {4{rf_we & (wb_wd != REG_W'(0))}};
        debug_wb_rf_wnum  = wb_wd;
        debug_wb_rf_wdata = wb_wdata;
    end

    // Same-cycle LLbit view for an SC sitting in MEM
    always_comb begin
        LLbit_fwd = LLbit_o;
        if (flush) begin
            LLbit_fwd = 1'b0;
        end else if (llbit_we) begin
            LLbit_fwd = wb_LLbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (hilo_we) begin
            hi_o <= wb_hi;
            lo_o <= wb_lo;
        end
    end

    // Flush breaks the link but never cancels the committed WB instruction
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            LLbit_o <= 1'b0;
        end else if (llbit_we) begin
            LLbit_o <= wb_LLbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
            last_pc <= RESET_PC;
        end else if (wb_valid) begin
            instret <= instret + DATA_W'(1);
            last_pc <= wb_pc;
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Directed self-checking bench for wb_commit with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_commit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;
    logic        LLbit_fwd;
    logic [31:0] instret;
    logic [31:0] last_pc;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_commit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wd(wb_wd),
        .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_LLbit_we(wb_LLbit_we),
        .wb_LLbit_value(wb_LLbit_value), .flush(flush), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_o(hi_o), .lo_o(lo_o),
        .LLbit_o(LLbit_o), .LLbit_fwd(LLbit_fwd), .instret(instret),
        .last_pc(last_pc), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = '0; wb_wd = '0; wb_wreg = 1'b0; wb_wdata = '0;
        wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0; wb_LLbit_we = 1'b0;
        wb_LLbit_value = 1'b0; flush = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // Reset with live, random WB traffic that must be ignored
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'b1; wb_pc = $urandom; wb_wd = 5'($urandom);
            wb_wreg = 1'b1; wb_wdata = $urandom; wb_whilo = 1'b1;
            wb_hi = $urandom; wb_lo = $urandom; wb_LLbit_we = 1'b1;
            wb_LLbit_value = 1'b1;
            step();
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_llbit", 32'(LLbit_o), 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_last_pc", last_pc, RST_PC);
        check("idle_dbg_pc", debug_wb_pc, RST_PC);

        // GPR write and trace
        wb_valid = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd8; wb_wdata = 32'hDEADBEEF;
        wb_pc = 32'hBFC0_0010;
        #1;
        check("rf_we", 32'(rf_we), 32'h1);
        check("rf_waddr", 32'(rf_waddr), 32'h8);
        check("rf_wdata", rf_wdata, 32'hDEADBEEF);
        check("dbg_wen", 32'(debug_wb_rf_wen), 32'hF);
        check("dbg_pc", debug_wb_pc, 32'hBFC0_0010);
        check("dbg_wnum", 32'(debug_wb_rf_wnum), 32'h8);
        check("dbg_wdata", debug_wb_rf_wdata, 32'hDEADBEEF);
        step();
        check("instret_1", instret, 32'h1);
        check("last_pc_1", last_pc, 32'hBFC0_0010);

        wb_wd = 5'd0; wb_pc = 32'hBFC0_0014;
        #1;
        check("r0_rf_we", 32'(rf_we), 32'h1);
        check("r0_dbg_wen", 32'(debug_wb_rf_wen), 32'h0);
        step();
        check("instret_2", instret, 32'h2);

        // Bubble: enables gated, trace PC falls back
        wb_valid = 1'b0; wb_wd = 5'd9; wb_pc = 32'h1111_2222;
        #1;
        check("bub_rf_we", 32'(rf_we), 32'h0);
        check("bub_dbg_wen", 32'(debug_wb_rf_wen), 32'h0);
        check("bub_dbg_pc", debug_wb_pc, RST_PC);
        wb_wreg = 1'b0;

        // HI/LO gating
        wb_valid = 1'b1; wb_whilo = 1'b1; wb_hi = 32'h1234; wb_lo = 32'h5678;
        wb_pc = 32'hBFC0_0018;
        #1;
        check("hi_not_yet", hi_o, 32'h0);
        step();
        check("hi_write", hi_o, 32'h1234);
        check("lo_write", lo_o, 32'h5678);
        wb_valid = 1'b0; wb_hi = 32'hAAAA; wb_lo = 32'hBBBB;
        step();
        check("hi_hold", hi_o, 32'h1234);
        check("lo_hold", lo_o, 32'h5678);
        check("instret_3", instret, 32'h3);
        check("last_pc_hold", last_pc, 32'hBFC0_0018);
        wb_whilo = 1'b0;

        // LL/SC link bit and flush
        wb_valid = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        #1;
        check("ll_fwd_set", 32'(LLbit_fwd), 32'h1);
        check("ll_o_before", 32'(LLbit_o), 32'h0);
        step();
        check("ll_o_set", 32'(LLbit_o), 32'h1);
        wb_valid = 1'b0; wb_LLbit_value = 1'b0;
        #1;
        check("ll_fwd_gated", 32'(LLbit_fwd), 32'h1);
        step();
        check("ll_o_gated", 32'(LLbit_o), 32'h1);
        wb_valid = 1'b1; wb_LLbit_value = 1'b1; flush = 1'b1;
        wb_whilo = 1'b1; wb_hi = 32'hCAFE; wb_lo = 32'hF00D; wb_pc = 32'hBFC0_0020;
        #1;
        check("flush_fwd", 32'(LLbit_fwd), 32'h0);
        step();
        check("flush_ll_o", 32'(LLbit_o), 32'h0);
        check("flush_hi", hi_o, 32'hCAFE);
        check("flush_lo", lo_o, 32'hF00D);
        check("flush_instret", instret, 32'h5);
        check("flush_last_pc", last_pc, 32'hBFC0_0020);
        idle_inputs();

        // Counter wrap from a forced preload
        force dut.instret = 32'hFFFF_FFFE;
        #1;
        release dut.instret;
        #1;
        check("preload", instret, 32'hFFFF_FFFE);
        wb_valid = 1'b1; wb_pc = 32'h0000_0100;
        step();
        check("wrap_ffff", instret, 32'hFFFF_FFFF);
        check("wrap_pc0", last_pc, 32'h0000_0100);
        wb_pc = 32'h0000_0104;
        step();
        check("wrap_zero", instret, 32'h0);
        check("wrap_pc1", last_pc, 32'h0000_0104);
        wb_pc = 32'h0000_0108;
        step();
        check("wrap_one", instret, 32'h1);
        check("wrap_pc2", last_pc, 32'h0000_0108);
        wb_valid = 1'b0; wb_pc = 32'h0000_0FFF;
        step();
        check("bub_instret", instret, 32'h1);
        check("bub_last_pc", last_pc, 32'h0000_0108);

        // Mid-stream reset beats a concurrent HI/LO write
        rst = 1'b1; wb_valid = 1'b1; wb_whilo = 1'b1; wb_hi = 32'h7777; wb_lo = 32'h8888;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        #1;
        check("rst_comb_rf_we", 32'(rf_we), 32'h0);
        step();
        check("mid_rst_hi", hi_o, 32'h0);
        check("mid_rst_lo", lo_o, 32'h0);
        check("mid_rst_ll", 32'(LLbit_o), 32'h0);
        check("mid_rst_cnt", instret, 32'h0);
        check("mid_rst_pc", last_pc, RST_PC);
        rst = 1'b0;
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
